// File: rtl/handshake_sequencer.sv
// SW8 handshake sequencer for the picoMIPS PC: sync/debounce the switch, then step
// IN X1 -> IN X2 -> compute run -> show Y1 -> show Y2 through a load/increment PC.
module handshake_sequencer #(
    parameter int Psize      = 4,
    parameter int DB_CYCLES  = 16,
    parameter int RUN_LEN    = 9,
    parameter int NOP_ADDR   = 0,
    parameter int IN1_ADDR   = 1,
    parameter int IN2_ADDR   = 2,
    parameter int RUN_ADDR   = 3,
    parameter int SHOW2_ADDR = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             SW8,
    output logic             pc_load,
    output logic             pc_incr,
    output logic [Psize-1:0] pc_target,
    output logic [3:0]       state_o,
    output logic             busy,
    output logic             done
);
    localparam int DB_W  = $clog2(DB_CYCLES) + 1;
    localparam int RUN_W = $clog2(RUN_LEN) + 1;
    localparam int LAST_RUN_ADDR = RUN_ADDR + RUN_LEN - 1;
    localparam bit ADDR_OK = (NOP_ADDR < (1 << Psize)) && (IN1_ADDR < (1 << Psize)) &&
                             (IN2_ADDR < (1 << Psize)) && (LAST_RUN_ADDR < (1 << Psize)) &&
                             (SHOW2_ADDR < (1 << Psize));

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        LD1      = 4'd1,
        WAIT_LO1 = 4'd2,
        WAIT_HI2 = 4'd3,
        LD2      = 4'd4,
        WAIT_LO2 = 4'd5,
        RUN      = 4'd6,
        SHOW1    = 4'd7,
        SHOW2    = 4'd8
    } state_t;

    logic [1:0]       sync_q, sync_d;
    logic             sw_db_q, sw_db_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             rise, fall;
    state_t           state_q, state_d;
    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Debounce: sw_db follows the synchronised input only after DB_CYCLES disagreeing samples.
    always_comb begin
        sync_d   = {sync_q[0], SW8};
        sw_db_d  = sw_db_q;
        db_cnt_d = '0;
        if (sync_q[1] != sw_db_q) begin
            if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
                sw_db_d = sync_q[1];
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Edges act in the same cycle sw_db flips, so the state moves 2+DB_CYCLES after SW8.
    assign rise = sw_db_d & ~sw_db_q;
    assign fall = ~sw_db_d & sw_db_q;

    always_comb begin
        state_d   = state_q;
        run_cnt_d = '0;
        done_d    = 1'b0;
        case (state_q)
            IDLE:     if (rise) state_d = LD1;
            LD1:      state_d = WAIT_LO1;
            WAIT_LO1: if (fall) state_d = WAIT_HI2;
            WAIT_HI2: if (rise) state_d = LD2;
            LD2:      state_d = WAIT_LO2;
            WAIT_LO2: if (fall) state_d = RUN;
            RUN: begin
                run_cnt_d = run_cnt_q + 1'b1;
                if (run_cnt_q == RUN_W'(RUN_LEN - 1)) begin
                    state_d   = SHOW1;
                    run_cnt_d = '0;
                    done_d    = 1'b1;
                end
            end
            SHOW1:    if (rise) state_d = SHOW2;
            SHOW2:    if (fall) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= '0;
            sw_db_q   <= 1'b0;
            db_cnt_q  <= '0;
            state_q   <= IDLE;
            run_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            sw_db_q   <= sw_db_d;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // PC controls are a pure decode of the registered state so IDLE parks on NOP during reset.
    always_comb begin
        pc_load   = 1'b0;
        pc_incr   = 1'b0;
        pc_target = '0;
        case (state_q)
            IDLE, WAIT_LO1, WAIT_HI2, WAIT_LO2: begin
                pc_load   = 1'b1;
                pc_target = Psize'(NOP_ADDR);
            end
            LD1: begin
                pc_load   = 1'b1;
                pc_target = Psize'(IN1_ADDR);
            end
            LD2: begin
                pc_load   = 1'b1;
                pc_target = Psize'(IN2_ADDR);
            end
            RUN: begin
                if (run_cnt_q == '0) begin
                    pc_load   = 1'b1;
                    pc_target = Psize'(RUN_ADDR);
                end else begin
                    pc_incr = 1'b1;
                end
            end
            SHOW1: ;
            SHOW2: begin
                pc_load   = 1'b1;
                pc_target = Psize'(SHOW2_ADDR);
            end
            default: begin
                pc_load   = 1'b1;
                pc_target = Psize'(NOP_ADDR);
            end
        endcase
    end

    assign state_o = state_q;
    assign busy    = busy_q;
    assign done    = done_q;

    a_addr_range: assert property (@(posedge clk) disable iff (!reset_n) ADDR_OK);
    a_load_incr_excl: assert property (@(posedge clk) disable iff (!reset_n) !(pc_load && pc_incr));

endmodule

// File: tb/tb_handshake_sequencer.sv
// Directed bench for handshake_sequencer with DB_CYCLES=4, RUN_LEN=9.
module tb_handshake_sequencer;
    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       sw8 = 1'b0;
    logic       pc_load, pc_incr, busy, done;
    logic [3:0] pc_target, state_o;

    always #5 clk = ~clk;

    handshake_sequencer #(
        .Psize(4), .DB_CYCLES(4), .RUN_LEN(9), .NOP_ADDR(0), .IN1_ADDR(1),
        .IN2_ADDR(2), .RUN_ADDR(3), .SHOW2_ADDR(12)
    ) dut (
        .clk(clk), .reset_n(reset_n), .SW8(sw8), .pc_load(pc_load), .pc_incr(pc_incr),
        .pc_target(pc_target), .state_o(state_o), .busy(busy), .done(done)
    );

    typedef struct {
        logic       sw;
        int         n;
        logic [3:0] st;
        logic       ld;
        logic       inc;
        logic [3:0] tgt;
        logic       bsy;
        logic       dn;
    } vec_t;

    vec_t vq[$];
    int n_checks = 0;
    int n_fail   = 0;
    int busy_cnt, incr_cnt, done_cnt, t1_cnt, t2_cnt, both_cnt, nz_cnt;

    function automatic logic [11:0] outv();
        return {state_o, pc_load, pc_incr, pc_target, busy, done};
    endfunction

    task automatic add(input logic sw, input int n, input logic [3:0] st, input logic ld,
                       input logic inc, input logic [3:0] tgt, input logic bsy, input logic dn);
        vec_t v;
        v.sw = sw; v.n = n; v.st = st; v.ld = ld; v.inc = inc; v.tgt = tgt; v.bsy = bsy; v.dn = dn;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_counts();
        busy_cnt = 0; incr_cnt = 0; done_cnt = 0; t1_cnt = 0; t2_cnt = 0; both_cnt = 0; nz_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (busy) busy_cnt++;
        if (pc_incr) incr_cnt++;
        if (done) done_cnt++;
        if (pc_load && pc_target == 4'd1) t1_cnt++;
        if (pc_load && pc_target == 4'd2) t2_cnt++;
        if (pc_load && pc_incr) both_cnt++;
        if (state_o != 4'd0) nz_cnt++;
    endtask

    task automatic hold(input logic s, input int n);
        sw8 = s;
        repeat (n) tick();
    endtask

    task automatic go_to_run(input string tag);
        hold(1'b1, 8);
        hold(1'b0, 8);
        hold(1'b1, 8);
        hold(1'b0, 6);
        check({tag, "_entry"}, 32'(outv()), 32'({4'd6, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0}));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        // Full handshake, each SW8 level held 20 cycles.
        add(0, 10, 4'd0, 1, 0, 4'd0,  0, 0);
        add(1,  5, 4'd0, 1, 0, 4'd0,  0, 0);
        add(1,  1, 4'd1, 1, 0, 4'd1,  0, 0);
        add(1,  1, 4'd2, 1, 0, 4'd0,  0, 0);
        add(1, 13, 4'd2, 1, 0, 4'd0,  0, 0);
        add(0,  5, 4'd2, 1, 0, 4'd0,  0, 0);
        add(0,  1, 4'd3, 1, 0, 4'd0,  0, 0);
        add(0, 14, 4'd3, 1, 0, 4'd0,  0, 0);
        add(1,  5, 4'd3, 1, 0, 4'd0,  0, 0);
        add(1,  1, 4'd4, 1, 0, 4'd2,  0, 0);
        add(1,  1, 4'd5, 1, 0, 4'd0,  0, 0);
        add(1, 13, 4'd5, 1, 0, 4'd0,  0, 0);
        add(0,  5, 4'd5, 1, 0, 4'd0,  0, 0);
        add(0,  1, 4'd6, 1, 0, 4'd3,  1, 0);
        add(0,  1, 4'd6, 0, 1, 4'd0,  1, 0);
        add(0,  7, 4'd6, 0, 1, 4'd0,  1, 0);
        add(0,  1, 4'd7, 0, 0, 4'd0,  0, 1);
        add(0,  1, 4'd7, 0, 0, 4'd0,  0, 0);
        add(0,  4, 4'd7, 0, 0, 4'd0,  0, 0);
        add(1,  5, 4'd7, 0, 0, 4'd0,  0, 0);
        add(1,  1, 4'd8, 1, 0, 4'd12, 0, 0);
        add(1, 14, 4'd8, 1, 0, 4'd12, 0, 0);
        add(0,  5, 4'd8, 1, 0, 4'd12, 0, 0);
        add(0,  1, 4'd0, 1, 0, 4'd0,  0, 0);
        add(0, 14, 4'd0, 1, 0, 4'd0,  0, 0);

        // Reset state, checked while reset is still asserted.
        #2 reset_n = 1'b0;
        #1 check("reset_state", 32'(outv()), 32'({4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0}));
        tick();
        tick();
        #3 reset_n = 1'b1;

        clr_counts();
        foreach (vq[i]) begin
            hold(vq[i].sw, vq[i].n);
            check($sformatf("vec%0d", i), 32'(outv()),
                  32'({vq[i].st, vq[i].ld, vq[i].inc, vq[i].tgt, vq[i].bsy, vq[i].dn}));
        end
        check("hs_busy_cycles", 32'(busy_cnt), 32'd9);
        check("hs_incr_cycles", 32'(incr_cnt), 32'd8);
        check("hs_done_pulses", 32'(done_cnt), 32'd1);
        check("hs_in1_cycles",  32'(t1_cnt),   32'd1);
        check("hs_in2_cycles",  32'(t2_cnt),   32'd1);
        check("hs_load_and_incr", 32'(both_cnt), 32'd0);

        // Bounce shorter than the debounce window never moves the FSM.
        clr_counts();
        repeat (4) begin
            hold(1'b1, 3);
            hold(1'b0, 3);
        end
        hold(1'b0, 4);
        check("bounce_state", 32'(state_o), 32'd0);
        check("bounce_no_move", 32'(nz_cnt), 32'd0);
        hold(1'b1, 5);
        check("db_before_edge", 32'(state_o), 32'd0);
        hold(1'b1, 1);
        check("db_ld1", 32'(outv()), 32'({4'd1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0}));
        hold(1'b1, 1);
        check("db_wait_lo1", 32'(state_o), 32'd2);
        hold(1'b0, 6);
        check("db_wait_hi2", 32'(state_o), 32'd3);

        // Asynchronous reset in WAIT_HI2.
        #2 reset_n = 1'b0;
        #1 check("rst_hi2_async", 32'(outv()), 32'({4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0}));
        tick();
        #3 reset_n = 1'b1;
        clr_counts();
        hold(1'b0, 20);
        check("rst_hi2_idle", 32'(state_o), 32'd0);
        check("rst_hi2_nz", 32'(nz_cnt), 32'd0);

        // SW8 raised during RUN: run completes, rise is lost.
        clr_counts();
        go_to_run("sw_in_run");
        hold(1'b1, 8);
        check("run_hi_incr", 32'(outv()), 32'({4'd6, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0}));
        hold(1'b1, 1);
        check("run_hi_done", 32'(outv()), 32'({4'd7, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1}));
        hold(1'b1, 10);
        check("run_hi_show1_hold", 32'(state_o), 32'd7);
        check("run_hi_busy_cycles", 32'(busy_cnt), 32'd9);
        check("run_hi_incr_cycles", 32'(incr_cnt), 32'd8);
        hold(1'b0, 6);
        check("show1_after_fall", 32'(state_o), 32'd7);
        hold(1'b1, 5);
        check("show1_before_rise", 32'(state_o), 32'd7);
        hold(1'b1, 1);
        check("show2_entry", 32'(outv()), 32'({4'd8, 1'b1, 1'b0, 4'd12, 1'b0, 1'b0}));
        hold(1'b0, 6);
        check("show2_to_idle", 32'(state_o), 32'd0);

        // Asynchronous reset in RUN.
        go_to_run("rst_run");
        hold(1'b0, 3);
        #2 reset_n = 1'b0;
        #1 check("rst_run_async", 32'(outv()), 32'({4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0}));
        tick();
        #3 reset_n = 1'b1;
        clr_counts();
        hold(1'b0, 20);
        check("rst_run_idle", 32'(state_o), 32'd0);
        check("rst_run_no_busy", 32'(busy_cnt), 32'd0);
        go_to_run("rerun");
        hold(1'b0, 9);
        check("rerun_show1", 32'(state_o), 32'd7);
        hold(1'b1, 6);
        hold(1'b0, 6);
        check("rerun_idle", 32'(state_o), 32'd0);

        // SW8 held high through reset release.
        sw8 = 1'b1;
        #2 reset_n = 1'b0;
        #1 check("rst_sw_hi_async", 32'(state_o), 32'd0);
        tick();
        tick();
        #3 reset_n = 1'b1;
        hold(1'b1, 5);
        check("rst_sw_hi_wait", 32'(state_o), 32'd0);
        hold(1'b1, 1);
        check("rst_sw_hi_ld1", 32'(outv()), 32'({4'd1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0}));
        hold(1'b1, 1);
        check("rst_sw_hi_wait_lo1", 32'(state_o), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
